// File: rtl/dmem_arb_pkg.sv
// Shared types and port identifiers for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned ARB_PORT_LSU = 0;
    localparam int unsigned ARB_PORT_DMA = 1;

    typedef struct packed {
        logic        store;
        logic [3:0]  byte_en;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } dmem_rsp_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_grant.sv
// Combinational one-hot picker: search starts at i_ptr and wraps; urgent requesters
// take precedence over plain ones when any is present.
module arb_grant
    import dmem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ-1:0]             i_urgent,
    input  logic [idx_width(NUM_REQ)-1:0]  i_ptr,
    output logic [NUM_REQ-1:0]             o_grant
);

    localparam int unsigned PORT_W = idx_width(NUM_REQ);
    localparam int unsigned SUM_W  = PORT_W + 1;

    logic [NUM_REQ-1:0] w_pool;
    logic [SUM_W-1:0]   w_sum;
    logic [PORT_W-1:0]  w_idx;
    logic               w_found;

    assign w_pool = (|(i_req & i_urgent)) ? (i_req & i_urgent) : i_req;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + SUM_W'(k);
            if (w_sum >= SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - SUM_W'(NUM_REQ);
            end
            w_idx = w_sum[PORT_W-1:0];
            if (!w_found && w_pool[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one bram_1r1w data memory between NUM_REQ valid/ready ports, 1-cycle read return.
// Define DMEM_ARB_RR_EN for round-robin; otherwise fixed priority with a MAX_WAIT starvation limit.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned MAX_WAIT   = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_store,
    input  logic [NUM_REQ-1:0][3:0]       req_byte_en,
    input  logic [NUM_REQ-1:0][31:0]      req_addr,
    input  logic [NUM_REQ-1:0][31:0]      req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [31:0]                   rsp_rdata,
    output logic [3:0]                    mem_wr_en,
    output logic [ADDR_WIDTH+1:0]         mem_addr,
    output logic [31:0]                   mem_wr_data,
    input  logic [31:0]                   mem_rd_data
);

    localparam int unsigned PORT_W = idx_width(NUM_REQ);

    dmem_req_t             w_req [NUM_REQ];
    dmem_req_t             w_sel;
    dmem_rsp_t             w_rsp;
    logic [NUM_REQ-1:0]    w_valid;
    logic [NUM_REQ-1:0]    w_grant;
    logic [NUM_REQ-1:0]    w_urgent;
    logic [PORT_W-1:0]     w_ptr;
    logic [PORT_W-1:0]     w_port;
    logic                  w_any;
    logic [ADDR_WIDTH+1:0] w_mem_addr;
    logic                  w_unused_addr;

    logic                  r_tag_valid;
    logic [PORT_W-1:0]     r_tag_port;
    logic [ADDR_WIDTH+1:0] r_addr;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign w_req[g] = '{store:   req_store[g],
                            byte_en: req_byte_en[g],
                            addr:    req_addr[g],
                            wdata:   req_wdata[g]};
    end

    // No grant may be issued while reset is held, even with valid requests present.
    assign w_valid = rst ? req_valid : '0;

    arb_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_grant (
        .i_req    (w_valid),
        .i_urgent (w_urgent),
        .i_ptr    (w_ptr),
        .o_grant  (w_grant)
    );

    always_comb begin
        w_port = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[PORT_W'(i)]) begin
                w_port = PORT_W'(i);
            end
        end
    end

    assign w_any = |w_grant;
    assign w_sel = w_req[w_port];

`ifdef DMEM_ARB_RR_EN
    logic [PORT_W-1:0] r_rr_ptr;

    assign w_ptr    = r_rr_ptr;
    assign w_urgent = '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= PORT_W'(ARB_PORT_LSU);
        end else if (w_any) begin
            r_rr_ptr <= (w_port == PORT_W'(NUM_REQ - 1)) ? '0 : w_port + 1'b1;
        end
    end
`else
    localparam int unsigned       CNT_W    = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;
    localparam logic [CNT_W-1:0]  WAIT_LIM = CNT_W'(MAX_WAIT);

    assign w_ptr = PORT_W'(ARB_PORT_LSU);

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_wait
        logic [CNT_W-1:0] r_wait_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wait_cnt <= '0;
            end else if (!req_valid[g] || w_grant[g]) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt < WAIT_LIM) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end

        assign w_urgent[g] = (r_wait_cnt >= WAIT_LIM);
    end
`endif

    assign req_ready     = w_grant;
    assign w_mem_addr    = w_any ? {w_sel.addr[ADDR_WIDTH+1:2], 2'b00} : r_addr;
    assign w_unused_addr = ^{w_sel.addr[31:ADDR_WIDTH+2], w_sel.addr[1:0]};
    assign mem_addr      = w_mem_addr;
    assign mem_wr_en     = (w_any && w_sel.store) ? w_sel.byte_en : 4'b0000;
    assign mem_wr_data   = w_any ? w_sel.wdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_valid <= 1'b0;
            r_tag_port  <= '0;
            r_addr      <= '0;
        end else begin
            r_tag_valid <= w_any && !w_sel.store;
            if (w_any) begin
                r_tag_port <= w_port;
                r_addr     <= w_mem_addr;
            end
        end
    end

    always_comb begin
        w_rsp.valid = r_tag_valid;
        w_rsp.rdata = r_tag_valid ? mem_rd_data : '0;
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
        assign rsp_valid[g] = w_rsp.valid && (r_tag_port == PORT_W'(g));
    end

    assign rsp_rdata = w_rsp.rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed and random traffic against a behavioural
// model; load responses are matched by a scoreboard monitor. Honours DMEM_ARB_RR_EN.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int NR    = 2;
    localparam int AW    = 12;
    localparam int MW    = 7;
    localparam int WORDS = 1 << AW;
    localparam logic [31:0] AMASK = ((32'd1 << (AW + 2)) - 32'd1) & ~32'd3;
`ifdef DMEM_ARB_RR_EN
    localparam int EXP_FIRST_DMA = 2;
`else
    localparam int EXP_FIRST_DMA = MW + 1;
`endif

    typedef struct {
        int          cyc;
        int          port;
        logic [31:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        req_valid, req_ready, req_store, rsp_valid;
    logic [NR-1:0][3:0]   req_byte_en;
    logic [NR-1:0][31:0]  req_addr, req_wdata;
    logic [31:0]          rsp_rdata, mem_wr_data, mem_rd_data;
    logic [3:0]           mem_wr_en;
    logic [AW+1:0]        mem_addr;

    logic [31:0] bram   [WORDS];
    logic [31:0] shadow [WORDS];
    int          m_wait [NR];
    int          m_ptr;
    logic [31:0] m_last;
    int          last_g;
    int          cyc = 0;
    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;

    dmem_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .MAX_WAIT   (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_store   (req_store),
        .req_byte_en (req_byte_en),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Block RAM stand-in: byte-lane write, registered read.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wr_en[b]) bram[mem_addr[AW+1:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
        end
        mem_rd_data <= bram[mem_addr[AW+1:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NR; p++) m_wait[p] = 0;
        m_ptr  = 0;
        m_last = '0;
        last_g = -1;
        q.delete();
    endtask

    function automatic int pick();
`ifdef DMEM_ARB_RR_EN
        for (int k = 0; k < NR; k++) begin
            if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
`else
        for (int p = 0; p < NR; p++) begin
            if (req_valid[p] && m_wait[p] >= MW) return p;
        end
        for (int p = 0; p < NR; p++) begin
            if (req_valid[p]) return p;
        end
`endif
        return -1;
    endfunction

    // Checks the combinational face of the current cycle, then advances the model to the next edge.
    task automatic tick();
        int          g;
        logic [31:0] ea;
        #1;
        g = pick();
        chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        if (g >= 0) begin
            ea = req_addr[g] & AMASK;
            chk("mem_addr", 32'(mem_addr), ea);
            if (req_store[g]) begin
                chk("mem_wr_en", 32'(mem_wr_en), 32'(req_byte_en[g]));
                chk("mem_wr_data", mem_wr_data, req_wdata[g]);
                for (int b = 0; b < 4; b++) begin
                    if (req_byte_en[g][b]) shadow[ea >> 2][8*b +: 8] = req_wdata[g][8*b +: 8];
                end
            end else begin
                chk("mem_wr_en_load", 32'(mem_wr_en), 32'd0);
                q.push_back('{cyc: cyc + 1, port: g, data: shadow[ea >> 2]});
            end
            m_last = ea;
            m_ptr  = (g + 1) % NR;
        end else begin
            chk("idle_wr_en", 32'(mem_wr_en), 32'd0);
            chk("idle_addr_hold", 32'(mem_addr), m_last);
        end
        for (int p = 0; p < NR; p++) begin
            if (req_valid[p] && p != g) m_wait[p]++;
            else m_wait[p] = 0;
        end
        last_g = g;
    endtask

    task automatic set_req(input int p, input logic st, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] wd);
        req_valid[p]   = 1'b1;
        req_store[p]   = st;
        req_byte_en[p] = be;
        req_addr[p]    = a;
        req_wdata[p]   = wd;
    endtask

    task automatic new_req(input int p);
        logic [31:0] a;
        a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_C000);
        if ($urandom_range(0, 7) == 0) a = a | 32'h0000_3FC0;
        set_req(p, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = '0;
            tick();
        end
    endtask

    // Scoreboard monitor: every load grant must answer on the next cycle, on its own port only.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("rsp_missed", 32'(e.cyc), 32'(cyc));
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'd1 << e.port);
                chk("rsp_rdata", rsp_rdata, e.data);
            end else begin
                chk("rsp_quiet", 32'(rsp_valid), 32'd0);
            end
        end
    end

    initial begin
        int          first_dma;
        logic [31:0] resume;
        logic [31:0] old_word;

        for (int i = 0; i < WORDS; i++) begin
            bram[i]   = $urandom;
            shadow[i] = bram[i];
        end
        rst         = 1'b0;
        req_valid   = '0;
        req_store   = '0;
        req_byte_en = '0;
        req_addr    = '0;
        req_wdata   = '0;
        model_reset();

        // Held in reset: a valid request must not be granted.
        repeat (2) @(negedge clk);
        set_req(ARB_PORT_LSU, 1'b1, 4'hF, 32'h10, 32'h1234_5678);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;

        // Reset asserted between a load grant and its capturing edge.
        @(negedge clk);
        set_req(ARB_PORT_LSU, 1'b0, 4'h0, 32'h10, 32'h0);
        req_valid[ARB_PORT_DMA] = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        model_reset();
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("midload_rsp", 32'(rsp_valid), 32'd0);
        chk("midload_rdata", rsp_rdata, 32'd0);
        chk("midload_ready", 32'(req_ready), 32'd0);
        chk("midload_wr_en", 32'(mem_wr_en), 32'd0);
        chk("midload_addr", 32'(mem_addr), 32'd0);
        chk("midload_wdata", mem_wr_data, 32'd0);
        rst = 1'b1;

        // Reset asserted while the read tag is already in flight.
        @(negedge clk);
        set_req(ARB_PORT_LSU, 1'b0, 4'h0, 32'h14, 32'h0);
        tick();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        req_valid = '0;
        #1;
        chk("inflight_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Both ports contend continuously.
        idle(1);
        first_dma = -1;
        resume    = '0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin
                set_req(ARB_PORT_LSU, 1'b0, 4'h0, 32'h20, 32'h0);
                set_req(ARB_PORT_DMA, 1'b0, 4'h0, 32'h24, 32'h0);
            end
            tick();
            if (first_dma < 0 && req_ready[ARB_PORT_DMA]) first_dma = c;
            if (c == 9) resume = 32'(req_ready);
        end
        chk("contend_first_dma", 32'(first_dma), 32'(EXP_FIRST_DMA));
        chk("contend_resume_lsu", resume, 32'd1);

        // Byte store followed immediately by a word load of the same word.
        idle(1);
        old_word = shadow[32'h100 >> 2];
        @(negedge clk);
        set_req(ARB_PORT_LSU, 1'b1, 4'b1000, 32'h103, 32'hAB00_0000);
        tick();
        @(negedge clk);
        set_req(ARB_PORT_LSU, 1'b0, 4'h0, 32'h100, 32'h0);
        tick();
        @(negedge clk);
        req_valid = '0;
        tick();
        chk("sb_lw_word", rsp_rdata, {8'hAB, old_word[23:0]});

        // Back-to-back loads from alternating ports.
        @(negedge clk);
        set_req(ARB_PORT_LSU, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        @(negedge clk);
        set_req(ARB_PORT_LSU, 1'b0, 4'h0, 32'h8, 32'h0);
        set_req(ARB_PORT_DMA, 1'b0, 4'h0, 32'h4, 32'h0);
        tick();
        @(negedge clk);
        tick();
        idle(1);

        // Address past the BRAM size folds back to word 0.
        @(negedge clk);
        set_req(ARB_PORT_LSU, 1'b0, 4'h0, 32'h4000, 32'h0);
        tick();
        chk("wrap_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        req_valid = '0;
        tick();
        chk("wrap_rdata", rsp_rdata, shadow[0]);

        // Five idle cycles.
        idle(5);

        // Random traffic: ungranted requests hold, occasionally withdraw.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            for (int p = 0; p < NR; p++) begin
                if (req_valid[p]) begin
                    if (last_g == p) begin
                        if ($urandom_range(0, 3) != 0) new_req(p);
                        else req_valid[p] = 1'b0;
                    end else if ($urandom_range(0, 19) == 0) begin
                        req_valid[p] = 1'b0;
                    end
                end else if ($urandom_range(0, 1) == 1) begin
                    new_req(p);
                end
            end
            tick();
        end

        idle(2);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
